gpio_irq: RTL
=============

Name: gpio_irq

Overview:
- Parametrised GPIO controller with NUM_IO pins.
- Per-pin mode: hi-Z, output or input.
- Input pins pass through a multi-stage synchroniser; output pins support atomic set/clear writes.
- Per-pin edge-triggered interrupts collect into a W1C pending register; irq_o goes to the core interrupt controller. Sits on the peripheral bus as a slave with the same single-cycle we/addr/data interface as the other peripherals.

Parameters:
- NUM_IO, 16, number of pins; legal range 1..16, because mode and edge fields are 2 bits per pin in one 32-bit register.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- we_i  input  1  write strobe, one cycle per write
- addr_i  input  32  byte address; only addr_i[4:0] decoded
- data_i  input  32  write data
- data_o  output  32  read data, combinational from addr_i
- io_pin_i  input  NUM_IO  raw asynchronous pin levels
- io_out_o  output  NUM_IO  output data register
- io_oe_o  output  NUM_IO  per-pin output enable; bit = (mode==OUT)
- irq_o  output  1  OR of all pending bits

Behaviour:
- Reset: rst_n sampled on posedge clk, active low, synchronous.
  - Clears all registers, sync chains and previous-sample flops.
  - Outputs during reset: io_out_o=0, io_oe_o=0, irq_o=0 from the cycle after the reset edge; data_o=0 while rst_n=0.
  - Reset mid-operation discards any edge in flight.
- Register map on addr_i[4:0]. Unmapped offsets read 0; writes to them are ignored.
  - 0x00 MODE: RW, 2 bits per pin. 00=hi-Z, 01=output, 10=input, 11=reserved (treated as hi-Z).
  - 0x04 DATA:
    - Write loads the out register.
    - Read returns, per pin, the out register bit if mode=01, the synced input if mode=10, else 0.
  - 0x08 SET: W-only; out |= data. Reads 0.
  - 0x0C CLR: W-only; out &= ~data. Reads 0.
  - 0x10 EDGE: RW, 2 bits per pin. 00=none, 01=rising, 10=falling, 11=both.
  - 0x14 PEND: read returns pending bits; write-1-to-clear.
- Width rules:
  - Bits at and above NUM_IO in DATA/SET/CLR/PEND are ignored on write and read 0.
  - Bits at and above 2*NUM_IO in MODE/EDGE are ignored on write and read 0.
- Register writes take effect at the posedge where we_i=1. Read data reflects the new value from the next cycle.
- Synchroniser:
  - sync[k] is a SYNC_STAGES-flop chain on io_pin_i[k]; prev[k] holds sync[k] delayed by one cycle.
  - Rise = sync & ~prev; fall = ~sync & prev.
- Edge detection:
  - Only evaluated when mode[k]=10 and EDGE[k]!=00.
  - Edges in other modes are dropped, never latched.
- Latency:
  - A pin transition meeting setup before edge t is visible on DATA reads after edge t+SYNC_STAGES-1.
  - PEND[k] sets at edge t+SYNC_STAGES; irq_o asserts in that same cycle (combinational from PEND).
- Simultaneous events:
  - A W1C of PEND[k] in the same cycle an edge sets PEND[k]: set wins, bit stays 1.
  - SET and CLR are separate offsets, so no same-cycle conflict is possible.
- Mode changes:
  - Switching a pin to input does not fabricate an edge, because prev tracks sync in all modes.
  - Changing EDGE does not clear PEND.
- Pulses shorter than one clk period may be missed. This is not an error.

Decomposition:
- Package gpio_pkg holds:
  - Register offset constants.
  - MODE encodings HIZ/OUT/IN.
  - EDGE encodings NONE/RISE/FALL/BOTH.
- Sub-module gpio_sync_edge, instantiated per pin via generate.
  - Parameter SYNC_STAGES.
  - Ports: clk, rst_n, pin_i, sync_o, rise_o, fall_o.
- Top level holds the register file, read mux, pending logic and irq OR.

Test Plan:
- Reset with io_pin_i=all-ones, then release -> after SYNC_STAGES+1 cycles: all reads 0, io_oe_o=0, irq_o=0, PEND=0.
- Output path, pin 3:
  - MODE=0x40 -> io_oe_o=0x0008.
  - DATA=0x0000, then SET=0x0008 -> io_out_o=0x0008.
  - CLR=0x0008 -> io_out_o=0x0000.
  - DATA read returns 0x0008 after the SET and 0x0000 after the CLR.
- Rising IRQ, pin 0:
  - MODE=0x2, EDGE=0x1, io_pin_i[0] 0->1 -> PEND=0x1 and irq_o=1 exactly SYNC_STAGES edges later.
  - 1->0 -> no new pending.
  - PEND write 0x1 -> irq_o=0 the next cycle.
- Both-edge on pin 15: NUM_IO=16, MODE[31:30]=10, EDGE[31:30]=11, toggle pin 15 twice -> PEND bit 15 set on each toggle; W1C clears it between toggles.
- Collision, pin 0 (rising edge enabled): W1C of PEND bit 0 issued in the same cycle a new edge arrives -> PEND[0] remains 1.
- Edge while pin 0 is hi-Z:
  - Pin 0 in mode 00 with a rising edge enabled, toggle the pin -> PEND stays 0.
  - Switch to input with the pin held high -> PEND stays 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the gpio_irq peripheral.
//   - BUS_W              : peripheral bus address/data width
//   - OFF_*              : register offsets decoded on addr_i[4:0]
//   - mode_e             : per-pin 2-bit mode encoding
//   - edge_e             : per-pin 2-bit interrupt edge selection
package gpio_pkg;

   localparam int BUS_W = 32;

   localparam logic [4:0] OFF_MODE = 5'h00;
   localparam logic [4:0] OFF_DATA = 5'h04;
   localparam logic [4:0] OFF_SET  = 5'h08;
   localparam logic [4:0] OFF_CLR  = 5'h0C;
   localparam logic [4:0] OFF_EDGE = 5'h10;
   localparam logic [4:0] OFF_PEND = 5'h14;

   // 2'b11 is reserved and behaves like hi-Z.
   typedef enum logic [1:0] {
      MODE_HIZ = 2'b00,
      MODE_OUT = 2'b01,
      MODE_IN  = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   // Bit 0 enables rising, bit 1 enables falling.
   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_e;

endpackage

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: single-cycle peripheral bus used by gpio_irq.
//   we_i   : write strobe, one cycle per write
//   addr_i : byte address
//   data_i : write data
//   data_o : read data, combinational from addr_i
// Modports: master (bus side), slave (peripheral side).
interface gpio_irq_if;
   import gpio_pkg::*;

   logic             we_i;
   logic [BUS_W-1:0] addr_i;
   logic [BUS_W-1:0] data_i;
   logic [BUS_W-1:0] data_o;

   modport master (output we_i, output addr_i, output data_i, input data_o);
   modport slave  (input we_i, input addr_i, input data_i, output data_o);

endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-pin input synchroniser plus edge detector.
//   clk, rst_n : clock, synchronous active-low reset
//   pin_i      : raw asynchronous pin level
//   sync_o     : synchronised level (last flop of the chain)
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
module gpio_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   prev;

   // prev follows sync regardless of pin mode, so a later mode change
   // never sees a stale level and cannot fabricate an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_chain <= '0;
         prev       <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin_i};
         prev       <= sync_chain[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_chain[SYNC_STAGES-1];
   assign rise_o = sync_o & ~prev;
   assign fall_o = ~sync_o & prev;

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: GPIO controller with per-pin mode, atomic set/clear output
// writes and edge-triggered interrupts collected in a W1C pending register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : peripheral bus slave (we_i/addr_i/data_i/data_o)
//   io_pin_i   : raw asynchronous pin levels
//   io_out_o   : output data register
//   io_oe_o    : per-pin output enable (mode == output)
//   irq_o      : OR of all pending bits
module gpio_irq
   import gpio_pkg::*;
#(
   parameter int NUM_IO      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   gpio_irq_if.slave         bus,
   input  logic [NUM_IO-1:0] io_pin_i,
   output logic [NUM_IO-1:0] io_out_o,
   output logic [NUM_IO-1:0] io_oe_o,
   output logic              irq_o
);

   logic [2*NUM_IO-1:0] mode_q;
   logic [2*NUM_IO-1:0] edge_q;
   logic [NUM_IO-1:0]   out_q;
   logic [NUM_IO-1:0]   pend_q;

   logic [NUM_IO-1:0]   sync_v;
   logic [NUM_IO-1:0]   rise_v;
   logic [NUM_IO-1:0]   fall_v;
   logic [NUM_IO-1:0]   is_in;
   logic [NUM_IO-1:0]   hit;
   logic [NUM_IO-1:0]   pin_rd;

   logic [4:0]          offset;
   logic                wr_mode, wr_data, wr_set, wr_clr, wr_edge, wr_pend;
   logic [BUS_W-1:0]    rdata;

   // Only the low five address bits are decoded.
   logic                unused_addr;
   assign unused_addr = ^bus.addr_i[BUS_W-1:5];

   assign offset  = bus.addr_i[4:0];
   assign wr_mode = bus.we_i && (offset == OFF_MODE);
   assign wr_data = bus.we_i && (offset == OFF_DATA);
   assign wr_set  = bus.we_i && (offset == OFF_SET);
   assign wr_clr  = bus.we_i && (offset == OFF_CLR);
   assign wr_edge = bus.we_i && (offset == OFF_EDGE);
   assign wr_pend = bus.we_i && (offset == OFF_PEND);

   for (genvar k = 0; k < NUM_IO; k++) begin : g_pin
      gpio_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
         .clk    (clk),
         .rst_n  (rst_n),
         .pin_i  (io_pin_i[k]),
         .sync_o (sync_v[k]),
         .rise_o (rise_v[k]),
         .fall_o (fall_v[k])
      );

      assign io_oe_o[k] = (mode_q[2*k +: 2] == MODE_OUT);
      assign is_in[k]   = (mode_q[2*k +: 2] == MODE_IN);

      // Edges on pins not in input mode are dropped, never latched.
      assign hit[k] = is_in[k] & ((edge_q[2*k]   & rise_v[k]) |
                                  (edge_q[2*k+1] & fall_v[k]));

      assign pin_rd[k] = io_oe_o[k] ? out_q[k] : (is_in[k] & sync_v[k]);
   end

   // Register file
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= '0;
         edge_q <= '0;
         out_q  <= '0;
         pend_q <= '0;
      end else begin
         if (wr_mode) mode_q <= bus.data_i[2*NUM_IO-1:0];
         if (wr_edge) edge_q <= bus.data_i[2*NUM_IO-1:0];

         if (wr_data)     out_q <= bus.data_i[NUM_IO-1:0];
         else if (wr_set) out_q <= out_q | bus.data_i[NUM_IO-1:0];
         else if (wr_clr) out_q <= out_q & ~bus.data_i[NUM_IO-1:0];

         // A new edge wins over a simultaneous write-1-to-clear.
         pend_q <= (pend_q & ~({NUM_IO{wr_pend}} & bus.data_i[NUM_IO-1:0])) | hit;
      end
   end

   // Read mux; forced to zero while reset is held.
   always_comb begin
      rdata = '0;
      if (rst_n) begin
         case (offset)
            OFF_MODE: rdata[2*NUM_IO-1:0] = mode_q;
            OFF_DATA: rdata[NUM_IO-1:0]   = pin_rd;
            OFF_EDGE: rdata[2*NUM_IO-1:0] = edge_q;
            OFF_PEND: rdata[NUM_IO-1:0]   = pend_q;
            default:  rdata = '0;
         endcase
      end
   end

   assign bus.data_o = rdata;
   assign io_out_o   = out_q;
   assign irq_o      = |pend_q;

endmodule
